diffeq_operand_tx: RTL and testbench

//  Operand transmitter for the differential-equation datapath.
//  - Accepts one operand set {x, dx, a, u} in parallel over a valid/ready handshake.
//  - Streams the set onto the datapath's 4-bit nibble bus, one value per load strobe, then pulses start.
//  - Double-buffered: the next set can be accepted while the current one is streaming.
//  - Sits between the host/test interface and the datapath's input port.

---
 rtl/diffeq_operand_tx_pkg.sv | 36 +++
 rtl/diffeq_operand_tx_operand_buf.sv | 43 ++++
 rtl/diffeq_operand_tx.sv | 150 +++++++++++++++
 tb/tb_diffeq_operand_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/diffeq_operand_tx_pkg.sv
// rtl/diffeq_operand_tx_pkg.sv - shared state encodings and constants for the operand transmitter
package diffeq_operand_tx_pkg;

   localparam int NIB_W_DEF = 4;
   localparam int GAP_MAX   = 15;

   // Transmitter FSM states
   typedef enum logic [2:0] {
      T_IDLE  = 3'd0,
      T_LD_X  = 3'd1,
      T_LD_DX = 3'd2,
      T_LD_A  = 3'd3,
      T_LD_U  = 3'd4,
      T_GAP   = 3'd5,
      T_START = 3'd6
   } tx_state_t;

   // Datapath controller states, kept here so both sides agree on encodings
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } dp_state_t;

   // Fixed operand order: x, dx, a, u, then start
   function automatic tx_state_t next_load(input tx_state_t s);
      case (s)
         T_LD_X:  return T_LD_DX;
         T_LD_DX: return T_LD_A;
         T_LD_A:  return T_LD_U;
         default: return T_START;
      endcase
   endfunction

endpackage

// File: rtl/diffeq_operand_tx_operand_buf.sv
// rtl/diffeq_operand_tx_operand_buf.sv - pending operand-set register with full flag
module diffeq_operand_tx_operand_buf #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_load,
   input  logic         i_clear,
   input  logic         i_abort,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q,
   output logic         o_full
);

   logic [W-1:0] r_data;
   logic         r_full;

   // Full flag: abort wins; load only happens when empty and clear only when full
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_full <= 1'b0;
      end else if (i_abort) begin
         r_full <= 1'b0;
      end else if (i_load) begin
         r_full <= 1'b1;
      end else if (i_clear) begin
         r_full <= 1'b0;
      end
   end

   // Capture the offered set on an accepted handshake
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data <= '0;
      end else if (i_load) begin
         r_data <= i_d;
      end
   end

   assign o_q    = r_data;
   assign o_full = r_full;

endmodule

// File: rtl/diffeq_operand_tx.sv
// rtl/diffeq_operand_tx.sv - double-buffered operand streamer onto the datapath nibble bus
module diffeq_operand_tx
   import diffeq_operand_tx_pkg::*;
#(
   parameter int NIB_W      = NIB_W_DEF,
   parameter int GAP_CYCLES = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [NIB_W-1:0] op_x,
   input  logic [NIB_W-1:0] op_dx,
   input  logic [NIB_W-1:0] op_a,
   input  logic [NIB_W-1:0] op_u,
   input  logic             dp_ready,
   input  logic             abort,
   output logic [NIB_W-1:0] in_nib,
   output logic             load_x,
   output logic             load_dx,
   output logic             load_a,
   output logic             load_u,
   output logic             start,
   output logic             busy
);

   localparam int SET_W = 4 * NIB_W;
   localparam logic [3:0] C_GAP_INIT = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   tx_state_t        r_state;
   tx_state_t        r_ret;
   logic [3:0]       r_gap_cnt;
   logic [SET_W-1:0] r_active;

   tx_state_t        w_next;
   tx_state_t        w_ret_nxt;
   logic [3:0]       w_cnt_nxt;
   logic [SET_W-1:0] w_pend;
   logic             w_full;
   logic             w_hs;
   logic             w_go;

   assign op_ready = !w_full && !abort;
   assign w_hs     = op_valid && op_ready;
   assign w_go     = (r_state == T_IDLE) && w_full && dp_ready && !abort;

   diffeq_operand_tx_operand_buf #(
      .W (SET_W)
   ) u_pend (
      .clk     (clk),
      .reset_n (reset_n),
      .i_load  (w_hs),
      .i_clear (w_go),
      .i_abort (abort),
      .i_d     ({op_x, op_dx, op_a, op_u}),
      .o_q     (w_pend),
      .o_full  (w_full)
   );

   // State, gap return target and gap counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= T_IDLE;
         r_ret     <= T_IDLE;
         r_gap_cnt <= '0;
      end else begin
         r_state   <= w_next;
         r_ret     <= w_ret_nxt;
         r_gap_cnt <= w_cnt_nxt;
      end
   end

   // Active set is copied from pending as the stream begins
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_active <= '0;
      end else if (w_go) begin
         r_active <= w_pend;
      end
   end

   // Next-state logic; abort overrides everything and returns to idle
   always_comb begin
      w_next    = r_state;
      w_ret_nxt = r_ret;
      w_cnt_nxt = r_gap_cnt;
      if (abort) begin
         w_next    = T_IDLE;
         w_ret_nxt = T_IDLE;
         w_cnt_nxt = '0;
      end else begin
         case (r_state)
            T_IDLE: begin
               if (w_go) w_next = T_LD_X;
            end
            T_LD_X, T_LD_DX, T_LD_A, T_LD_U: begin
               if (GAP_CYCLES > 0) begin
                  w_next    = T_GAP;
                  w_ret_nxt = next_load(r_state);
                  w_cnt_nxt = C_GAP_INIT;
               end else begin
                  w_next = next_load(r_state);
               end
            end
            T_GAP: begin
               if (r_gap_cnt == 4'd0) begin
                  w_next = r_ret;
               end else begin
                  w_cnt_nxt = r_gap_cnt - 4'd1;
               end
            end
            T_START: w_next = T_IDLE;
            default: w_next = T_IDLE;
         endcase
      end
   end

   // Moore output decode: one strobe at a time, bus zero outside strobes
   always_comb begin
      load_x  = 1'b0;
      load_dx = 1'b0;
      load_a  = 1'b0;
      load_u  = 1'b0;
      start   = 1'b0;
      in_nib  = '0;
      case (r_state)
         T_LD_X: begin
            load_x = 1'b1;
            in_nib = r_active[3*NIB_W +: NIB_W];
         end
         T_LD_DX: begin
            load_dx = 1'b1;
            in_nib  = r_active[2*NIB_W +: NIB_W];
         end
         T_LD_A: begin
            load_a = 1'b1;
            in_nib = r_active[NIB_W +: NIB_W];
         end
         T_LD_U: begin
            load_u = 1'b1;
            in_nib = r_active[0 +: NIB_W];
         end
         T_START: start = 1'b1;
         default: ;
      endcase
   end

   assign busy = (r_state != T_IDLE);

endmodule

// File: tb/tb_diffeq_operand_tx.sv
// tb/tb_diffeq_operand_tx.sv - directed self-checking bench for diffeq_operand_tx
module tb_diffeq_operand_tx;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       op_valid;
   logic [3:0] op_x, op_dx, op_a, op_u;
   logic       dp_ready;
   logic       abort;

   logic       op_ready0, load_x0, load_dx0, load_a0, load_u0, start0, busy0;
   logic [3:0] in_nib0;
   logic       op_readyg, load_xg, load_dxg, load_ag, load_ug, startg, busyg;
   logic [3:0] in_nibg;

   logic [9:0] v0, vg;
   assign v0 = {load_x0, load_dx0, load_a0, load_u0, start0, busy0, in_nib0};
   assign vg = {load_xg, load_dxg, load_ag, load_ug, startg, busyg, in_nibg};

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   diffeq_operand_tx #(.NIB_W(4), .GAP_CYCLES(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready0),
      .op_x(op_x), .op_dx(op_dx), .op_a(op_a), .op_u(op_u),
      .dp_ready(dp_ready), .abort(abort), .in_nib(in_nib0),
      .load_x(load_x0), .load_dx(load_dx0), .load_a(load_a0), .load_u(load_u0),
      .start(start0), .busy(busy0)
   );

   diffeq_operand_tx #(.NIB_W(4), .GAP_CYCLES(2)) dutg (
      .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_readyg),
      .op_x(op_x), .op_dx(op_dx), .op_a(op_a), .op_u(op_u),
      .dp_ready(dp_ready), .abort(abort), .in_nib(in_nibg),
      .load_x(load_xg), .load_dx(load_dxg), .load_a(load_ag), .load_u(load_ug),
      .start(startg), .busy(busyg)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [9:0] ev(input logic [3:0] ld, input logic st, input logic bz,
                                     input logic [3:0] nib);
      return {ld, st, bz, nib};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_set(input logic [3:0] x, input logic [3:0] dx,
                            input logic [3:0] a, input logic [3:0] u);
      op_valid = 1'b1;
      op_x = x; op_dx = dx; op_a = a; op_u = u;
   endtask

   task automatic reset_all();
      reset_n = 1'b0; op_valid = 1'b0; abort = 1'b0; dp_ready = 1'b0;
      op_x = '0; op_dx = '0; op_a = '0; op_u = '0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   // Called in the cycle after the transfer edge; ends in the idle cycle after start
   task automatic expect_stream0(input string tag, input logic [3:0] x, input logic [3:0] dx,
                                 input logic [3:0] a, input logic [3:0] u);
      check({tag, "_x"},     v0, ev(4'b1000, 1'b0, 1'b1, x));  tick();
      check({tag, "_dx"},    v0, ev(4'b0100, 1'b0, 1'b1, dx)); tick();
      check({tag, "_a"},     v0, ev(4'b0010, 1'b0, 1'b1, a));  tick();
      check({tag, "_u"},     v0, ev(4'b0001, 1'b0, 1'b1, u));  tick();
      check({tag, "_start"}, v0, ev(4'b0000, 1'b1, 1'b1, 4'd0)); tick();
      check({tag, "_idle"},  v0, 10'd0);
   endtask

   logic [9:0] gap_exp [14];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      reset_all();
      check("rst_outs", v0, 10'd0);
      check("rst_rdy", op_ready0, 1'b1);

      // Test 1: reset asserted while in LD_DX
      dp_ready = 1'b1;
      drive_set(4'd5, 4'd1, 4'd9, 4'd3);
      tick();
      op_valid = 1'b0;
      tick();
      tick();
      check("t1_in_dx", v0, ev(4'b0100, 1'b0, 1'b1, 4'd1));
      reset_n = 1'b0;
      #1;
      check("t1_rst_outs", v0, 10'd0);
      check("t1_rst_rdy", op_ready0, 1'b1);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      check("t1_no_start", v0, 10'd0);

      // Test 2: single set, GAP=0
      reset_all();
      dp_ready = 1'b1;
      drive_set(4'd5, 4'd1, 4'd9, 4'd3);
      check("t2_rdy", op_ready0, 1'b1);
      tick();
      op_valid = 1'b0;
      check("t2_e0_idle", v0, 10'd0);
      tick();
      expect_stream0("t2", 4'd5, 4'd1, 4'd9, 4'd3);

      // Test 3: dp_ready held low after handshake
      reset_all();
      dp_ready = 1'b0;
      drive_set(4'd4, 4'd6, 4'd8, 4'd2);
      tick();
      op_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check("t3_wait_outs", v0, 10'd0);
         check("t3_wait_rdy", op_ready0, 1'b0);
         tick();
      end
      dp_ready = 1'b1;
      check("t3_still_idle", v0, 10'd0);
      tick();
      expect_stream0("t3", 4'd4, 4'd6, 4'd8, 4'd2);

      // Test 4: back-to-back sets, third offer stalls
      reset_all();
      dp_ready = 1'b1;
      drive_set(4'd5, 4'd1, 4'd9, 4'd3);
      tick();
      drive_set(4'd2, 4'd2, 4'd7, 4'd1);
      check("t4_full_rdy", op_ready0, 1'b0);
      tick();
      check("t4_s1_x", v0, ev(4'b1000, 1'b0, 1'b1, 4'd5));
      check("t4_rdy_open", op_ready0, 1'b1);
      tick();
      drive_set(4'd8, 4'd8, 4'd8, 4'd8);
      check("t4_s1_dx", v0, ev(4'b0100, 1'b0, 1'b1, 4'd1));
      check("t4_stall_dx", op_ready0, 1'b0);
      tick();
      check("t4_s1_a", v0, ev(4'b0010, 1'b0, 1'b1, 4'd9));
      check("t4_stall_a", op_ready0, 1'b0);
      tick();
      check("t4_s1_u", v0, ev(4'b0001, 1'b0, 1'b1, 4'd3));
      tick();
      check("t4_s1_start", v0, ev(4'b0000, 1'b1, 1'b1, 4'd0));
      check("t4_stall_start", op_ready0, 1'b0);
      tick();
      check("t4_mid_idle", v0, 10'd0);
      check("t4_stall_idle", op_ready0, 1'b0);
      op_valid = 1'b0;
      tick();
      expect_stream0("t4_s2", 4'd2, 4'd2, 4'd7, 4'd1);
      check("t4_end_rdy", op_ready0, 1'b1);
      tick();
      check("t4_no_third", v0, 10'd0);

      // Test 5: GAP_CYCLES=2 instance
      gap_exp[0]  = ev(4'b1000, 1'b0, 1'b1, 4'd5);
      gap_exp[1]  = ev(4'b0000, 1'b0, 1'b1, 4'd0);
      gap_exp[2]  = ev(4'b0000, 1'b0, 1'b1, 4'd0);
      gap_exp[3]  = ev(4'b0100, 1'b0, 1'b1, 4'd1);
      gap_exp[4]  = ev(4'b0000, 1'b0, 1'b1, 4'd0);
      gap_exp[5]  = ev(4'b0000, 1'b0, 1'b1, 4'd0);
      gap_exp[6]  = ev(4'b0010, 1'b0, 1'b1, 4'd9);
      gap_exp[7]  = ev(4'b0000, 1'b0, 1'b1, 4'd0);
      gap_exp[8]  = ev(4'b0000, 1'b0, 1'b1, 4'd0);
      gap_exp[9]  = ev(4'b0001, 1'b0, 1'b1, 4'd3);
      gap_exp[10] = ev(4'b0000, 1'b0, 1'b1, 4'd0);
      gap_exp[11] = ev(4'b0000, 1'b0, 1'b1, 4'd0);
      gap_exp[12] = ev(4'b0000, 1'b1, 1'b1, 4'd0);
      gap_exp[13] = 10'd0;
      reset_all();
      dp_ready = 1'b1;
      drive_set(4'd5, 4'd1, 4'd9, 4'd3);
      tick();
      op_valid = 1'b0;
      tick();
      for (int i = 0; i < 14; i++) begin
         check($sformatf("t5_gap_c%0d", i), vg, gap_exp[i]);
         tick();
      end

      // Test 6: abort in LD_A with a pending set
      reset_all();
      dp_ready = 1'b1;
      drive_set(4'd5, 4'd1, 4'd9, 4'd3);
      tick();
      drive_set(4'd2, 4'd2, 4'd7, 4'd1);
      tick();
      tick();
      op_valid = 1'b0;
      check("t6_pend_full", op_ready0, 1'b0);
      tick();
      check("t6_in_a", v0, ev(4'b0010, 1'b0, 1'b1, 4'd9));
      abort = 1'b1;
      #1;
      check("t6_abort_rdy", op_ready0, 1'b0);
      tick();
      abort = 1'b0;
      #1;
      check("t6_post_idle", v0, 10'd0);
      check("t6_post_rdy", op_ready0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t6_quiet", v0, 10'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
